// File: rtl/ray_sphere_shader.sv
// Ray/sphere intersection shader: takes one ray direction per handshake, tests it
// against a single sphere and writes a shaded pixel to the framebuffer in raster order.
module ray_sphere_shader #(
    parameter int unsigned COORD_W   = 16,
    parameter logic [23:0] HIT_COLOR = 24'hFF0000,
    parameter logic [23:0] BG_COLOR  = 24'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ray_valid,
    output logic        ray_ready,
    input  logic [31:0] ray_dir_x,
    input  logic [31:0] ray_dir_y,
    input  logic [31:0] ray_dir_z,
    input  logic [10:0] camera_pos_x,
    input  logic [10:0] camera_pos_y,
    input  logic [10:0] camera_pos_z,
    input  logic [10:0] sphere_x,
    input  logic [10:0] sphere_y,
    input  logic [10:0] sphere_z,
    input  logic [10:0] sphere_radius,
    input  logic [12:0] image_width,
    input  logic [12:0] image_height,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [25:0] pix_addr,
    output logic [23:0] pix_color,
    output logic        frame_done
);

    localparam int unsigned POS_W  = 11;
    localparam int unsigned DIM_W  = 13;
    localparam int unsigned ADDR_W = 26;
    localparam int unsigned OC_W   = POS_W + 1;
    localparam int unsigned DD_W   = 2 * COORD_W + 2;
    localparam int unsigned OCD_W  = OC_W + COORD_W + 2;
    localparam int unsigned C_W    = 27;
    localparam int unsigned P_W    = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DOT,
        S_PROD,
        S_DECIDE,
        S_WRITE
    } state_t;

    state_t state, next_state;

    // Captured ray and scene
    logic signed [COORD_W-1:0] dx_q, dy_q, dz_q;
    logic [POS_W-1:0]          cam_x_q, cam_y_q, cam_z_q;
    logic [POS_W-1:0]          sph_x_q, sph_y_q, sph_z_q;
    logic [POS_W-1:0]          rad_q;
    logic [DIM_W-1:0]          width_q, height_q;

    // Pipeline intermediates
    logic signed [DD_W-1:0]  dd_q;
    logic signed [OCD_W-1:0] ocd_q;
    logic signed [C_W-1:0]   c_q;
    logic signed [P_W-1:0]   p1_q, p2_q;

    // Raster position
    logic [DIM_W-1:0] x_q, y_q;

    logic                     accept_c;
    logic signed [OC_W-1:0]   ocx_c, ocy_c, ocz_c;
    logic signed [DD_W-1:0]   dd_c;
    logic signed [OCD_W-1:0]  ocd_c;
    logic signed [C_W-1:0]    c_c, rad_e_c;
    logic signed [P_W-1:0]    p1_c, p2_c;
    logic                     hit_c;
    logic [DIM_W-1:0]         w_eff_c, h_eff_c;
    logic [ADDR_W-1:0]        addr_c;
    logic                     unused_dir_hi;

    assign accept_c = ray_valid && ray_ready;

    assign unused_dir_hi = ^{ray_dir_x[31:COORD_W], ray_dir_y[31:COORD_W], ray_dir_z[31:COORD_W]};

    // Arithmetic for the DOT, PROD and DECIDE steps
    always_comb begin
        ocx_c   = $signed({1'b0, cam_x_q}) - $signed({1'b0, sph_x_q});
        ocy_c   = $signed({1'b0, cam_y_q}) - $signed({1'b0, sph_y_q});
        ocz_c   = $signed({1'b0, cam_z_q}) - $signed({1'b0, sph_z_q});
        dd_c    = DD_W'(dx_q) * DD_W'(dx_q) + DD_W'(dy_q) * DD_W'(dy_q) + DD_W'(dz_q) * DD_W'(dz_q);
        ocd_c   = OCD_W'(ocx_c) * OCD_W'(dx_q) + OCD_W'(ocy_c) * OCD_W'(dy_q)
                + OCD_W'(ocz_c) * OCD_W'(dz_q);
        rad_e_c = $signed(C_W'(rad_q));
        c_c     = C_W'(ocx_c) * C_W'(ocx_c) + C_W'(ocy_c) * C_W'(ocy_c) + C_W'(ocz_c) * C_W'(ocz_c)
                - rad_e_c * rad_e_c;
        p1_c    = P_W'(ocd_q) * P_W'(ocd_q);
        p2_c    = P_W'(dd_q) * P_W'(c_q);
        // Inside the sphere always hits; otherwise the sphere must lie ahead and the
        // discriminant be non-negative (tangent counts as a hit)
        hit_c   = c_q[C_W-1] || (ocd_q[OCD_W-1] && (p1_q >= p2_q));
        w_eff_c = (width_q  == '0) ? DIM_W'(1) : width_q;
        h_eff_c = (height_q == '0) ? DIM_W'(1) : height_q;
        addr_c  = ADDR_W'(y_q) * ADDR_W'(w_eff_c) + ADDR_W'(x_q);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept_c) next_state = S_DOT;
            S_DOT:    next_state = S_PROD;
            S_PROD:   next_state = S_DECIDE;
            S_DECIDE: next_state = S_WRITE;
            S_WRITE:  if (pix_ready) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Datapath, pixel output and raster counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ray_ready  <= 1'b0;
            pix_valid  <= 1'b0;
            pix_addr   <= '0;
            pix_color  <= '0;
            frame_done <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            dz_q       <= '0;
            cam_x_q    <= '0;
            cam_y_q    <= '0;
            cam_z_q    <= '0;
            sph_x_q    <= '0;
            sph_y_q    <= '0;
            sph_z_q    <= '0;
            rad_q      <= '0;
            width_q    <= '0;
            height_q   <= '0;
            dd_q       <= '0;
            ocd_q      <= '0;
            c_q        <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
        end else begin
            ray_ready  <= (next_state == S_IDLE);
            frame_done <= 1'b0;
            if (accept_c) begin
                dx_q     <= $signed(ray_dir_x[COORD_W-1:0]);
                dy_q     <= $signed(ray_dir_y[COORD_W-1:0]);
                dz_q     <= $signed(ray_dir_z[COORD_W-1:0]);
                cam_x_q  <= camera_pos_x;
                cam_y_q  <= camera_pos_y;
                cam_z_q  <= camera_pos_z;
                sph_x_q  <= sphere_x;
                sph_y_q  <= sphere_y;
                sph_z_q  <= sphere_z;
                rad_q    <= sphere_radius;
                width_q  <= image_width;
                height_q <= image_height;
            end
            if (state == S_DOT) begin
                dd_q  <= dd_c;
                ocd_q <= ocd_c;
                c_q   <= c_c;
            end
            if (state == S_PROD) begin
                p1_q <= p1_c;
                p2_q <= p2_c;
            end
            if (state == S_DECIDE) begin
                pix_valid <= 1'b1;
                pix_addr  <= addr_c;
                pix_color <= hit_c ? HIT_COLOR : BG_COLOR;
            end
            if ((state == S_WRITE) && pix_ready) begin
                pix_valid <= 1'b0;
                if (x_q == w_eff_c - DIM_W'(1)) begin
                    x_q <= '0;
                    if (y_q == h_eff_c - DIM_W'(1)) begin
                        y_q        <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        y_q <= y_q + DIM_W'(1);
                    end
                end else begin
                    x_q <= x_q + DIM_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ray_sphere_shader.sv
// Scoreboard bench for ray_sphere_shader: stimulus pushes expected pixels, a monitor
// pops and compares them on every framebuffer handshake.
module tb_ray_sphere_shader;

    localparam logic [23:0] HIT = 24'hFF0000;
    localparam logic [23:0] BG  = 24'h000000;

    logic        clk;
    logic        reset_n;
    logic        ray_valid;
    logic        ray_ready;
    logic [31:0] ray_dir_x, ray_dir_y, ray_dir_z;
    logic [10:0] camera_pos_x, camera_pos_y, camera_pos_z;
    logic [10:0] sphere_x, sphere_y, sphere_z, sphere_radius;
    logic [12:0] image_width, image_height;
    logic        pix_valid;
    logic        pix_ready;
    logic [25:0] pix_addr;
    logic [23:0] pix_color;
    logic        frame_done;

    ray_sphere_shader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ray_valid    (ray_valid),
        .ray_ready    (ray_ready),
        .ray_dir_x    (ray_dir_x),
        .ray_dir_y    (ray_dir_y),
        .ray_dir_z    (ray_dir_z),
        .camera_pos_x (camera_pos_x),
        .camera_pos_y (camera_pos_y),
        .camera_pos_z (camera_pos_z),
        .sphere_x     (sphere_x),
        .sphere_y     (sphere_y),
        .sphere_z     (sphere_z),
        .sphere_radius(sphere_radius),
        .image_width  (image_width),
        .image_height (image_height),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_addr     (pix_addr),
        .pix_color    (pix_color),
        .frame_done   (frame_done)
    );

    typedef struct packed {
        logic [25:0] addr;
        logic [23:0] color;
        logic        fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   passes;
    int   writes;
    int   fd_count;
    logic fd_pending;
    logic fd_exp;
    int   mx, my, mw, mh;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    // Reference raster model: expected address and frame_done for the next pixel
    task automatic push_expect(input logic [23:0] color);
        exp_t e;
        e.addr  = 26'(my * mw + mx);
        e.color = color;
        e.fd    = (mx == mw - 1) && (my == mh - 1);
        if (mx == mw - 1) begin
            mx = 0;
            my = (my == mh - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare each framebuffer handshake against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (fd_pending) begin
            check("frame_done", longint'(frame_done), longint'(fd_exp));
            fd_pending = 1'b0;
        end
        if (frame_done) fd_count++;
        if (reset_n && pix_valid && pix_ready) begin
            writes++;
            check("write_expected", longint'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pix_addr", longint'(pix_addr), longint'(e.addr));
                check("pix_color", longint'(pix_color), longint'(e.color));
                fd_pending = 1'b1;
                fd_exp     = e.fd;
            end
        end
    end

    task automatic do_reset(input int w, input int h);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ray_ready_in_reset", longint'(ray_ready), 0);
        image_width  = 13'(w);
        image_height = 13'(h);
        mx = 0; my = 0; mw = w; mh = h;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ray_ready", longint'(ray_ready), 1);
        check("rst_pix_valid", longint'(pix_valid), 0);
        check("rst_frame_done", longint'(frame_done), 0);
        check("rst_pix_addr", longint'(pix_addr), 0);
    endtask

    task automatic send_ray(input int dx, input int dy, input int dz,
                            input logic [23:0] color, input int hold, input bit drop);
        int          n;
        int          lat;
        logic [25:0] a0;
        logic [23:0] c0;
        n = 0;
        @(negedge clk);
        while (!ray_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ray_ready_wait", longint'(ray_ready), 1);
        ray_valid = 1'b1;
        ray_dir_x = dx;
        ray_dir_y = dy;
        ray_dir_z = dz;
        if (!drop) push_expect(color);
        @(posedge clk);
        #1;
        ray_valid = 1'b0;
        ray_dir_x = $urandom;
        ray_dir_y = $urandom;
        ray_dir_z = $urandom;
        if (drop) begin
            @(posedge clk);
            #1;
            reset_n = 1'b0;
            repeat (3) begin
                @(posedge clk);
                #1;
                check("drop_pix_valid", longint'(pix_valid), 0);
                check("drop_ray_ready", longint'(ray_ready), 0);
            end
            mx = 0; my = 0;
            reset_n = 1'b1;
            repeat (4) begin
                @(posedge clk);
                #1;
                check("post_drop_pix_valid", longint'(pix_valid), 0);
            end
            return;
        end
        if (hold > 0) pix_ready = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (pix_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", longint'(lat), 3);
        if (hold > 0) begin
            a0 = pix_addr;
            c0 = pix_color;
            repeat (hold) begin
                @(posedge clk);
                #1;
                check("bp_valid", longint'(pix_valid), 1);
                check("bp_addr", longint'(pix_addr), longint'(a0));
                check("bp_color", longint'(pix_color), longint'(c0));
                check("bp_ray_ready", longint'(ray_ready), 0);
            end
            pix_ready = 1'b1;
        end
        n = 0;
        while (pix_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("write_drained", longint'(pix_valid), 0);
    endtask

    initial begin
        checks = 0; passes = 0; writes = 0; fd_count = 0;
        fd_pending = 1'b0; fd_exp = 1'b0;
        mx = 0; my = 0; mw = 1; mh = 1;
        reset_n   = 1'b0;
        ray_valid = 1'b0;
        pix_ready = 1'b1;
        ray_dir_x = '0; ray_dir_y = '0; ray_dir_z = '0;
        camera_pos_x = 11'd1000; camera_pos_y = 11'd1000; camera_pos_z = 11'd0;
        sphere_x = 11'd1000; sphere_y = 11'd1000; sphere_z = 11'd500;
        sphere_radius = 11'd100;
        image_width = 13'd4; image_height = 13'd4;

        do_reset(4, 4);
        send_ray(0, 0, 500, HIT, 0, 1'b0);
        send_ray(300, 0, 500, BG, 0, 1'b0);
        send_ray(0, 0, -500, BG, 0, 1'b0);
        send_ray(0, 0, 0, BG, 0, 1'b0);
        send_ray(0, 0, 500, HIT, 5, 1'b0);

        send_ray(0, 0, 500, HIT, 0, 1'b1);
        send_ray(0, 0, 500, HIT, 0, 1'b0);

        do_reset(2, 2);
        send_ray(0, 0, 500, HIT, 0, 1'b0);
        send_ray(300, 0, 500, BG, 0, 1'b0);
        sphere_z = 11'd50;
        send_ray(0, 0, 0, HIT, 0, 1'b0);
        sphere_z = 11'd500;
        send_ray(0, 0, -500, BG, 0, 1'b0);
        send_ray(0, 0, 500, HIT, 0, 1'b0);

        repeat (10) @(posedge clk);
        #1;
        check("queue_empty", longint'(exp_q.size()), 0);
        check("write_count", longint'(writes), 11);
        check("frame_done_pulses", longint'(fd_count), 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule
